// File: rtl/adsr_voice_scheduler.sv
// Shares one ADSR envelope voice among NUM_REQ requesters: round-robin grant, latch the winner's envelope
// settings, hold the gate for the requested time, then wait for the envelope to go idle before the next grant.
module adsr_voice_scheduler #(
    parameter int               NUM_REQ = 4,
    parameter int               DUR_W   = 16,
    parameter int               TMO_W   = 16,
    parameter logic [TMO_W-1:0] REL_TMO = 16'hFFFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [32*NUM_REQ-1:0]    req_cfg_i,
    input  logic [DUR_W*NUM_REQ-1:0] req_dur_i,
    input  logic                     abort_i,
    input  logic                     env_idle_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     tmo_o,
    output logic                     gate_o,
    output logic [7:0]               attack_o,
    output logic [7:0]               decay_o,
    output logic [7:0]               sustain_o,
    output logic [7:0]               rel_o,
    output logic                     busy_o,
    output logic [2:0]               active_id_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GATE = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [DUR_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tcnt_q, tcnt_d;
    logic               blank_q, blank_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         id_q, id_d;
    logic [31:0]        cfg_q, cfg_d;
    logic               gate_q, gate_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               tmo_q, tmo_d;

    logic               win_vld;
    logic [2:0]         win_idx;
    logic [NUM_REQ-1:0] req_sh;
    logic [31:0]        win_cfg;
    logic [DUR_W-1:0]   win_dur;
    logic [NUM_REQ-1:0] one_hot_lsb;

    assign one_hot_lsb = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Walk offsets from the highest down so the lowest offset from ptr wins.
    always_comb begin
        int cand;
        cand    = 0;
        win_vld = 1'b0;
        win_idx = '0;
        req_sh  = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = int'(ptr_q) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            req_sh = req_i >> cand;
            if (req_sh[0]) begin
                win_vld = 1'b1;
                win_idx = 3'(cand);
            end
        end
    end

    assign win_cfg = 32'(req_cfg_i >> (32 * int'(win_idx)));
    assign win_dur = DUR_W'(req_dur_i >> (DUR_W * int'(win_idx)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        blank_d = blank_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cfg_d   = cfg_q;
        gate_d  = gate_q;
        grant_d = '0;
        done_d  = '0;
        tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                gate_d = 1'b0;
                if (win_vld) begin
                    state_d = S_GATE;
                    gate_d  = 1'b1;
                    grant_d = one_hot_lsb << win_idx;
                    cfg_d   = win_cfg;
                    id_d    = win_idx;
                    cnt_d   = (win_dur == '0) ? '0 : win_dur - 1'b1;
                    ptr_d   = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
                end
            end
            S_GATE: begin
                if (cnt_q == '0 || abort_i) begin
                    state_d = S_REL;
                    gate_d  = 1'b0;
                    tcnt_d  = REL_TMO;
                    blank_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_REL: begin
                // The first cycle here is blanking: the datapath has not yet seen the gate fall.
                gate_d  = 1'b0;
                blank_d = 1'b0;
                if (!blank_q && env_idle_i) begin
                    state_d = S_DONE;
                    done_d  = one_hot_lsb << id_q;
                end else if (tcnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = one_hot_lsb << id_q;
                    tmo_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gate_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gate_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            blank_q <= 1'b0;
            ptr_q   <= '0;
            id_q    <= '0;
            cfg_q   <= '0;
            gate_q  <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            blank_q <= blank_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cfg_q   <= cfg_d;
            gate_q  <= gate_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign tmo_o       = tmo_q;
    assign gate_o      = gate_q;
    assign attack_o    = cfg_q[31:24];
    assign decay_o     = cfg_q[23:16];
    assign sustain_o   = cfg_q[15:8];
    assign rel_o       = cfg_q[7:0];
    assign busy_o      = (state_q != S_IDLE);
    assign active_id_o = id_q;

endmodule

// File: tb/tb_adsr_voice_scheduler.sv
// Note-level bench: a pending-request set and round-robin pointer predict each winner, gate length and release length.
module tb_adsr_voice_scheduler;
    localparam int NR = 4;
    localparam int DW = 16;
    localparam int RT = 8;

    logic              clk, rst_n;
    logic [NR-1:0]     req_i;
    logic [32*NR-1:0]  req_cfg_i;
    logic [DW*NR-1:0]  req_dur_i;
    logic              abort_i, env_idle_i;
    logic [NR-1:0]     grant_o, done_o;
    logic              tmo_o, gate_o, busy_o;
    logic [7:0]        attack_o, decay_o, sustain_o, rel_o;
    logic [2:0]        active_id_o;

    logic [31:0]       cfg [NR];
    logic [DW-1:0]     dur [NR];
    logic [NR-1:0]     pending;
    int                ptr;
    int                n_vec, n_err;

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign req_cfg_i[32*g +: 32] = cfg[g];
        assign req_dur_i[DW*g +: DW] = dur[g];
    end

    adsr_voice_scheduler #(.NUM_REQ(NR), .DUR_W(DW), .TMO_W(16), .REL_TMO(16'(RT))) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_cfg_i(req_cfg_i), .req_dur_i(req_dur_i),
        .abort_i(abort_i), .env_idle_i(env_idle_i), .grant_o(grant_o), .done_o(done_o), .tmo_o(tmo_o),
        .gate_o(gate_o), .attack_o(attack_o), .decay_o(decay_o), .sustain_o(sustain_o), .rel_o(rel_o),
        .busy_o(busy_o), .active_id_o(active_id_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < NR; k++) begin
            if (pending[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [31:0] settings();
        return {attack_o, decay_o, sustain_o, rel_o};
    endfunction

    // Entered #1 after an edge with the DUT idle; returns #1 after the edge that brings it back to idle.
    task automatic run_note(input logic [NR-1:0] add, input logic [NR-1:0] add_mid,
                            input int abort_at, input int idle_at);
        int w, d, glen, rlen, n, m, jj;
        logic etmo;
        logic [31:0] ecfg;
        pending = pending | add;
        if (pending == '0) pending[$urandom_range(0, NR-1)] = 1'b1;
        req_i = pending;
        w     = pick();
        ecfg  = cfg[w];
        d     = (dur[w] == '0) ? 1 : int'(dur[w]);
        glen  = (abort_at >= 0 && abort_at < d) ? abort_at + 1 : d;
        jj    = (idle_at < 1) ? 1 : idle_at;
        etmo  = (jj > RT);
        rlen  = etmo ? RT + 1 : jj + 1;
        ptr   = (w + 1) % NR;

        @(posedge clk); #1;
        check("grant", 32'(grant_o), 32'(1 << w));
        check("active_id", 32'(active_id_o), 32'(w));
        check("settings", settings(), ecfg);
        check("busy_gate", 32'(busy_o), 32'd1);
        pending[w] = 1'b0;
        pending    = pending | add_mid;
        req_i      = pending;
        cfg[w]     = $urandom;
        dur[w]     = DW'($urandom_range(0, 9));

        n = 0;
        while (gate_o === 1'b1 && n < 300) begin
            abort_i    = (n == abort_at);
            env_idle_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        abort_i = 1'b0;
        check("gate_len", 32'(n), 32'(glen));
        check("grant_pulse", 32'(grant_o), 32'd0);
        check("settings_hold", settings(), ecfg);

        m = 0;
        while (m < 40) begin
            env_idle_i = (m >= idle_at);
            abort_i    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            m++;
            if (done_o != '0) break;
        end
        abort_i    = 1'b0;
        env_idle_i = 1'b1;
        check("rel_len", 32'(m), 32'(rlen));
        check("done", 32'(done_o), 32'(1 << w));
        check("tmo", 32'(tmo_o), 32'(etmo));
        check("gate_done", 32'(gate_o), 32'd0);

        @(posedge clk); #1;
        check("idle_busy", 32'(busy_o), 32'd0);
        check("idle_pulses", {24'd0, grant_o, done_o}, 32'd0);
        check("idle_settings", settings(), ecfg);
    endtask

    initial begin
        int w;
        n_vec = 0; n_err = 0; ptr = 0; pending = '0;
        rst_n = 1'b0; req_i = '0; abort_i = 1'b0; env_idle_i = 1'b1;
        for (int i = 0; i < NR; i++) begin
            cfg[i] = 32'h1000_0000 * (i + 1) + 32'h0102_0304;
            dur[i] = 16'd1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", {grant_o, done_o, tmo_o, gate_o, busy_o, active_id_o}, 32'd0);
        check("rst_settings", settings(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        cfg[0] = 32'h1122_3344; dur[0] = 16'd3;
        run_note(4'b0001, '0, -1, 0);

        for (int i = 0; i < NR; i++) dur[i] = 16'd1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NR; i++) dur[i] = 16'd1;
            run_note(4'b1111, '0, -1, 0);
        end

        for (int i = 0; i < NR; i++) dur[i] = 16'd0;
        run_note(4'b0100, '0, -1, 2);

        for (int i = 0; i < NR; i++) dur[i] = 16'd100;
        run_note(4'b0010, '0, 10, 3);

        for (int i = 0; i < NR; i++) dur[i] = 16'd2;
        run_note(4'b1000, '0, -1, 20);
        run_note(4'b0001, '0, -1, RT);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NR; i++) begin
                cfg[i] = $urandom;
                dur[i] = DW'($urandom_range(0, 7));
            end
            run_note(NR'($urandom), NR'($urandom & $urandom),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1,
                     int'($urandom_range(0, 11)));
        end

        for (int i = 0; i < NR; i++) dur[i] = 16'd5;
        pending = pending | 4'b0101;
        w = pick();
        pending[w] = 1'b0;
        req_i = pending;
        @(posedge clk); #1;
        check("pre_rst_gate", 32'(gate_o), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {grant_o, done_o, tmo_o, gate_o, busy_o, active_id_o}, 32'd0);
        check("mid_rst_settings", settings(), 32'd0);
        ptr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_done", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        cfg[0] = 32'hA5A5_5A5A;
        run_note(4'b1111, '0, -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
